pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game-level sequencer for the pong ball datapath. Drives the ball block's `rst` and `pause` inputs from a Moore state machine, samples its `win[1:0]` outputs to score points, and holds the score counters and game-over logic. Sits between the button/frame-timing logic and the ball block; score outputs feed the display.

## Interface
- `SCORE_WIDTH`, 4: width of each score counter.
- `WIN_SCORE`, 7: points needed to win (1 ≤ WIN_SCORE ≤ 2^SCORE_WIDTH−1).
- `SERVE_DELAY`, 60: frame ticks the ball is held in reset before play (≥1).
- `POINT_HOLD`, 30: frame ticks the ball stays frozen after a point (≥1).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `start_btn` in 1: synchronized, debounced level; rising edge = start.
- `pause_btn` in 1: synchronized, debounced level; rising edge = pause toggle.
- `win` in 2: from ball block. `win[1]` = ball exited right, left player scores. `win[0]` = ball exited left, right player scores.
- `ball_rst` out 1: drives ball `rst`.
- `ball_pause` out 1: drives ball `pause`.
- `score_l`, `score_r` out SCORE_WIDTH: player scores.
- `state` out 3: current state encoding, for debug/display.
- `game_over` out 1: high in GAMEOVER.
- `winner` out 1: 0 = left, 1 = right; valid while `game_over`.
- `point_pulse` out 1: one-cycle pulse when a point is scored.

## Operation
- States and encodings: IDLE=0, SERVE=1, PLAY=2, PAUSED=3, POINT=4, GAMEOVER=5.
- All outputs are decoded from registers; there is no combinational path from input to output.
- Outputs by state:
  - `ball_rst`=1 in IDLE and SERVE, else 0.
  - `ball_pause`=1 in PAUSED and POINT, else 0.
- Edge detectors: registered copies of `start_btn`/`pause_btn`. An edge is current=1 and previous=0. Both registers are cleared by `rst`.
- Frame counter:
  - Cleared on every state entry.
  - Increments on `frame_tick`.
  - Width is `$clog2(max(SERVE_DELAY,POINT_HOLD)+1)`.
- IDLE:
  - Start edge: clear both scores, go to SERVE.
- SERVE:
  - On a `frame_tick` with count == SERVE_DELAY−1, go to PLAY.
- PLAY, evaluated in priority order:
  1. `win[1]`: `score_l`+1, go to POINT.
  2. `win[0]`: `score_r`+1, go to POINT.
  3. Pause edge: go to PAUSED.
- `win` is sampled only in PLAY. If `win`=2'b11, only `win[1]` counts.
- A point and a pause edge in the same cycle: the point wins and the pause edge is discarded.
- PAUSED:
  - Pause edge: return to PLAY. `win` is ignored.
- POINT:
  - On a `frame_tick` with count == POINT_HOLD−1:
    - If either score == WIN_SCORE, go to GAMEOVER; `winner` is set to the side at WIN_SCORE.
    - Otherwise go to SERVE.
- GAMEOVER:
  - Start edge: clear scores, clear `winner`, go to SERVE.
- Start edges outside IDLE/GAMEOVER are ignored. Pause edges outside PLAY/PAUSED are ignored.
- Scores never wrap, because the game ends at WIN_SCORE.
- `rst` mid-operation in any state: next cycle is IDLE with all outputs at reset values. A pending tick or edge is discarded.

## Timing
- Reset values:
  - `state`=IDLE, `ball_rst`=1, `ball_pause`=0.
  - `score_l`=`score_r`=0, `game_over`=0, `winner`=0, `point_pulse`=0.
  - Frame counter and edge registers = 0.
- State transitions take effect the cycle after the triggering condition.
- Point scoring:
  - The score increment and `point_pulse` are visible on the same cycle that `state`=POINT first appears.
  - `point_pulse` lasts exactly one cycle.
- SERVE lasts SERVE_DELAY `frame_tick`s. `ball_rst` is therefore held for many cycles, which clears the ball's internal previous-position registers before PLAY.
- Button edge to state change: 2 cycles from the button rising (edge register, then state register).
- A `frame_tick` on the cycle of state entry is counted.

## Test plan
- Reset, then start edge. Expect:
  - IDLE → SERVE.
  - After 60 ticks, PLAY with `ball_rst`=0 and `ball_pause`=0.
  - Scores 0/0.
- In PLAY, drive `win`=2'b10 for one cycle. Expect:
  - `score_l`=1 and a one-cycle `point_pulse`.
  - `ball_pause`=1 for 30 ticks, then SERVE.
- Drive `win`=2'b11 in PLAY: only `score_l` increments. Drive a pause edge together with `win[0]`: `score_r` increments and state goes to POINT, not PAUSED.
- Pause edge in PLAY. Expect:
  - PAUSED with `ball_pause`=1; `win`=2'b01 is ignored and the score is unchanged.
  - A second pause edge returns to PLAY.
- Score 7 right points. Expect:
  - After POINT_HOLD, GAMEOVER with `game_over`=1, `winner`=1, `score_r`=7.
  - A start edge clears scores and enters SERVE.
- Assert `rst` in POINT mid-count. Expect IDLE, scores 0, `ball_rst`=1 on the next cycle; a held `start_btn` does not start until it is released and pressed again.

Source files
------------

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pong_game_ctrl
//  Purpose  : Game sequencer for the pong ball block: serve/play/pause/point
//             state machine, score counters and game-over detection.
//  Revision : 1.0  initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int unsigned SCORE_WIDTH = 4,
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned SERVE_DELAY = 60,
    parameter int unsigned POINT_HOLD  = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   start_btn,
    input  logic                   pause_btn,
    input  logic [1:0]             win,
    output logic                   ball_rst,
    output logic                   ball_pause,
    output logic [SCORE_WIDTH-1:0] score_l,
    output logic [SCORE_WIDTH-1:0] score_r,
    output logic [2:0]             state,
    output logic                   game_over,
    output logic                   winner,
    output logic                   point_pulse
);

    localparam int unsigned MAX_DELAY = (SERVE_DELAY > POINT_HOLD) ? SERVE_DELAY : POINT_HOLD;
    localparam int unsigned CNT_W     = $clog2(MAX_DELAY + 1);

    localparam logic [CNT_W-1:0]       SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [CNT_W-1:0]       POINT_LAST = CNT_W'(POINT_HOLD - 1);
    localparam logic [SCORE_WIDTH-1:0] WIN_VAL    = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [SCORE_WIDTH-1:0] SCORE_ONE  = SCORE_WIDTH'(1);
    localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_PAUSED   = 3'd3,
        ST_POINT    = 3'd4,
        ST_GAMEOVER = 3'd5
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SCORE_WIDTH-1:0]   score_l_q, score_l_d;
    logic [SCORE_WIDTH-1:0]   score_r_q, score_r_d;
    logic                     winner_q, winner_d;
    logic                     point_pulse_q, point_pulse_d;

    logic start_cur_q, start_prev_q, start_arm_q;
    logic pause_cur_q, pause_prev_q;
    logic start_edge, pause_edge;

    // Start is only armed once the button has been seen released since reset,
    // so a button held through reset cannot start a game.
    assign start_edge = start_cur_q & ~start_prev_q & start_arm_q;
    assign pause_edge = pause_cur_q & ~pause_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            score_l_q     <= '0;
            score_r_q     <= '0;
            winner_q      <= 1'b0;
            point_pulse_q <= 1'b0;
            start_cur_q   <= 1'b0;
            start_prev_q  <= 1'b0;
            start_arm_q   <= 1'b0;
            pause_cur_q   <= 1'b0;
            pause_prev_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            winner_q      <= winner_d;
            point_pulse_q <= point_pulse_d;
            start_cur_q   <= start_btn;
            start_prev_q  <= start_cur_q;
            start_arm_q   <= start_arm_q | ~start_btn;
            pause_cur_q   <= pause_btn;
            pause_prev_q  <= pause_cur_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        winner_d      = winner_q;
        point_pulse_d = 1'b0;
        cnt_d         = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    state_d   = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (frame_tick && (cnt_q == SERVE_LAST)) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A point outranks a simultaneous pause edge, which is dropped.
                if (win[1]) begin
                    score_l_d     = score_l_q + SCORE_ONE;
                    point_pulse_d = 1'b1;
                    state_d       = ST_POINT;
                end else if (win[0]) begin
                    score_r_d     = score_r_q + SCORE_ONE;
                    point_pulse_d = 1'b1;
                    state_d       = ST_POINT;
                end else if (pause_edge) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (pause_edge) begin
                    state_d = ST_PLAY;
                end
            end
            ST_POINT: begin
                if (frame_tick && (cnt_q == POINT_LAST)) begin
                    if ((score_l_q == WIN_VAL) || (score_r_q == WIN_VAL)) begin
                        winner_d = (score_r_q == WIN_VAL);
                        state_d  = ST_GAMEOVER;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_GAMEOVER: begin
                if (start_edge) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    winner_d  = 1'b0;
                    state_d   = ST_SERVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counter restarts on state entry; a tick in the entry cycle counts.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (frame_tick) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign state       = state_q;
    assign ball_rst    = (state_q == ST_IDLE) || (state_q == ST_SERVE);
    assign ball_pause  = (state_q == ST_PAUSED) || (state_q == ST_POINT);
    assign game_over   = (state_q == ST_GAMEOVER);
    assign winner      = winner_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign point_pulse = point_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_game_ctrl
//  Purpose  : Directed plus randomized bench for pong_game_ctrl against a
//             behavioural game model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam int SW          = 4;
    localparam int WIN_SCORE   = 7;
    localparam int SERVE_DELAY = 60;
    localparam int POINT_HOLD  = 30;

    localparam int PH_IDLE = 0, PH_SERVE = 1, PH_PLAY = 2, PH_PAUSED = 3, PH_POINT = 4, PH_OVER = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_tick = 1'b0;
    logic          start_btn = 1'b0;
    logic          pause_btn = 1'b0;
    logic [1:0]    win = 2'b00;
    logic          ball_rst, ball_pause, game_over, winner, point_pulse;
    logic [SW-1:0] score_l, score_r;
    logic [2:0]    state;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .SCORE_WIDTH (SW),
        .WIN_SCORE   (WIN_SCORE),
        .SERVE_DELAY (SERVE_DELAY),
        .POINT_HOLD  (POINT_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .pause_btn   (pause_btn),
        .win         (win),
        .ball_rst    (ball_rst),
        .ball_pause  (ball_pause),
        .score_l     (score_l),
        .score_r     (score_r),
        .state       (state),
        .game_over   (game_over),
        .winner      (winner),
        .point_pulse (point_pulse)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Game model: phase, ticks seen in phase, scores, and button sample history.
    int phase = PH_IDLE;
    int ticks_in_phase = 0;
    int pts_l = 0, pts_r = 0;
    int champ = 0;
    int pulse = 0;
    bit s_hist1 = 0, s_hist2 = 0, s_released = 0;
    bit p_hist1 = 0, p_hist2 = 0;
    bit sb_lvl = 0, pb_lvl = 0;

    task automatic model_step(input bit r, input bit sb, input bit pb, input logic [1:0] w, input bit tk);
        int nxt;
        bit press_start, press_pause;
        if (r) begin
            phase = PH_IDLE; ticks_in_phase = 0; pts_l = 0; pts_r = 0; champ = 0; pulse = 0;
            s_hist1 = 0; s_hist2 = 0; s_released = 0; p_hist1 = 0; p_hist2 = 0;
            return;
        end
        press_start = s_hist1 && !s_hist2 && s_released;
        press_pause = p_hist1 && !p_hist2;
        nxt   = phase;
        pulse = 0;
        if (phase == PH_IDLE && press_start) begin
            pts_l = 0; pts_r = 0; nxt = PH_SERVE;
        end else if (phase == PH_SERVE && tk && ticks_in_phase + 1 == SERVE_DELAY) begin
            nxt = PH_PLAY;
        end else if (phase == PH_PLAY) begin
            if (w[1])          begin pts_l++; pulse = 1; nxt = PH_POINT; end
            else if (w[0])     begin pts_r++; pulse = 1; nxt = PH_POINT; end
            else if (press_pause) nxt = PH_PAUSED;
        end else if (phase == PH_PAUSED && press_pause) begin
            nxt = PH_PLAY;
        end else if (phase == PH_POINT && tk && ticks_in_phase + 1 == POINT_HOLD) begin
            if (pts_l == WIN_SCORE || pts_r == WIN_SCORE) begin
                champ = (pts_r == WIN_SCORE) ? 1 : 0;
                nxt   = PH_OVER;
            end else begin
                nxt = PH_SERVE;
            end
        end else if (phase == PH_OVER && press_start) begin
            pts_l = 0; pts_r = 0; champ = 0; nxt = PH_SERVE;
        end
        ticks_in_phase = (nxt != phase) ? 0 : ticks_in_phase + int'(tk);
        phase = nxt;
        s_hist2 = s_hist1; s_hist1 = sb; s_released = s_released || !sb;
        p_hist2 = p_hist1; p_hist1 = pb;
    endtask

    task automatic compare_all();
        check_eq("state",       32'(state),       32'(phase));
        check_eq("score_l",     32'(score_l),     32'(pts_l));
        check_eq("score_r",     32'(score_r),     32'(pts_r));
        check_eq("point_pulse", 32'(point_pulse), 32'(pulse));
        check_eq("winner",      32'(winner),      32'(champ));
        check_eq("ball_rst",    32'(ball_rst),    (phase == PH_IDLE || phase == PH_SERVE) ? 32'd1 : 32'd0);
        check_eq("ball_pause",  32'(ball_pause),  (phase == PH_PAUSED || phase == PH_POINT) ? 32'd1 : 32'd0);
        check_eq("game_over",   32'(game_over),   (phase == PH_OVER) ? 32'd1 : 32'd0);
    endtask

    task automatic step(input bit r, input logic [1:0] w, input bit tk);
        @(negedge clk);
        rst = r; start_btn = sb_lvl; pause_btn = pb_lvl; win = w; frame_tick = tk;
        @(posedge clk);
        model_step(r, sb_lvl, pb_lvl, w, tk);
        #1;
        compare_all();
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (phase != target && n < budget) begin
            step(1'b0, 2'b00, 1'($urandom_range(0, 1)));
            n++;
        end
        if (phase != target) check_eq("timeout_phase", 32'(phase), 32'(target));
    endtask

    task automatic tap_start();
        sb_lvl = 1; step(1'b0, 2'b00, 1'b0); step(1'b0, 2'b00, 1'b0);
        sb_lvl = 0;
    endtask

    task automatic tap_pause();
        pb_lvl = 1; step(1'b0, 2'b00, 1'b0); step(1'b0, 2'b00, 1'b0);
        pb_lvl = 0; step(1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b1);

        // Start, full serve, play
        tap_start();
        run_until(PH_PLAY, 400);

        // Left point, hold, re-serve
        step(1'b0, 2'b10, 1'b1);
        step(1'b0, 2'b00, 1'b1);
        run_until(PH_PLAY, 600);

        // Both exits at once: left only
        step(1'b0, 2'b11, 1'b0);
        run_until(PH_PLAY, 600);

        // Pause edge coincident with a right point
        pb_lvl = 1; step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b01, 1'b0);
        pb_lvl = 0;
        run_until(PH_PLAY, 600);

        // Paused: win ignored, then resume
        tap_pause();
        step(1'b0, 2'b01, 1'b1);
        step(1'b0, 2'b10, 1'b0);
        tap_pause();
        step(1'b0, 2'b00, 1'b0);

        // Right player runs out the game
        n = 0;
        while (phase != PH_OVER && n < 4000) begin
            step(1'b0, (phase == PH_PLAY) ? 2'b01 : 2'b00, 1'($urandom_range(0, 1)));
            n++;
        end
        if (phase != PH_OVER) check_eq("timeout_gameover", 32'(phase), 32'(PH_OVER));
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 1'b1);
        tap_start();
        run_until(PH_PLAY, 400);

        // Reset in POINT mid-count with start held through reset
        step(1'b0, 2'b10, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 2'b00, 1'b1);
        sb_lvl = 1;
        step(1'b1, 2'b00, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 2'b00, 1'b1);
        sb_lvl = 0;
        step(1'b0, 2'b00, 1'b0);
        tap_start();
        step(1'b0, 2'b00, 1'b0);

        // Randomized play
        for (int i = 0; i < 15000; i++) begin
            logic [1:0] w;
            if ($urandom_range(0, 39) == 0) sb_lvl = ~sb_lvl;
            if ($urandom_range(0, 29) == 0) pb_lvl = ~pb_lvl;
            w = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            step(1'($urandom_range(0, 3999) == 0), w, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
